// File: rtl/lsu_exec_unit.sv
`default_nettype none
// lsu_exec_unit: single-issue LW/SW execution stage with a word-addressed data
// memory and a request/grant CDB port for load results.
// Revision: 1.0
module lsu_exec_unit #(
  parameter  int MEM_DEPTH = 256,
  localparam int AW        = $clog2(MEM_DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issueque_ready,
  input  logic [31:0] issueque_rs_data,
  input  logic [31:0] issueque_rt_data,
  input  logic [31:0] issueque_imm,
  input  logic [5:0]  issueque_rd_tag,
  input  logic        issueque_opcode,
  output logic        issueblk_done,
  output logic        cdb_req,
  input  logic        cdb_grant,
  output logic [5:0]  cdb_out_tag,
  output logic [31:0] cdb_out_data,
  output logic        lsu_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_op;
  logic [5:0]    r_tag;
  logic [31:0]   r_rt;
  logic [31:0]   r_ea;
  logic [5:0]    r_cdb_tag;
  logic [31:0]   r_cdb_data;
  logic [31:0]   r_mem [MEM_DEPTH];

  logic          w_accept;
  logic [AW-1:0] w_idx;
  logic          w_unused;

  // Byte offset and bits above the array are dropped, so addresses alias.
  assign w_idx    = r_ea[AW+1:2];
  assign w_unused = ^{r_ea[31:AW+2], r_ea[1:0]};

  assign w_accept      = (r_state == IDLE) && issueque_ready && !reset;
  assign issueblk_done = w_accept;
  assign cdb_req       = (r_state == WB);
  assign lsu_busy      = (r_state != IDLE);
  assign cdb_out_tag   = r_cdb_tag;
  assign cdb_out_data  = r_cdb_data;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = EXEC;
      EXEC:    w_next = r_op ? IDLE : WB;
      WB:      if (cdb_grant) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_op       <= 1'b0;
      r_tag      <= 6'd0;
      r_rt       <= 32'd0;
      r_ea       <= 32'd0;
      r_cdb_tag  <= 6'd0;
      r_cdb_data <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op  <= issueque_opcode;
        r_tag <= issueque_rd_tag;
        r_rt  <= issueque_rt_data;
        r_ea  <= issueque_rs_data + issueque_imm;
      end
      // Load result is captured once and then held until the next load.
      if (r_state == EXEC && !r_op) begin
        r_cdb_tag  <= r_tag;
        r_cdb_data <= r_mem[w_idx];
      end
    end
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (r_state == EXEC && r_op) begin
      r_mem[w_idx] <= r_rt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_exec_unit.sv
`default_nettype none
// tb_lsu_exec_unit: directed and randomized checks of lsu_exec_unit against
// an array-based memory model.
// Revision: 1.0
module tb_lsu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        issueque_ready;
  logic [31:0] issueque_rs_data;
  logic [31:0] issueque_rt_data;
  logic [31:0] issueque_imm;
  logic [5:0]  issueque_rd_tag;
  logic        issueque_opcode;
  logic        issueblk_done;
  logic        cdb_req;
  logic        cdb_grant;
  logic [5:0]  cdb_out_tag;
  logic [31:0] cdb_out_data;
  logic        lsu_busy;

  lsu_exec_unit #(.MEM_DEPTH(256)) dut (
    .clk              (clk),
    .reset            (reset),
    .issueque_ready   (issueque_ready),
    .issueque_rs_data (issueque_rs_data),
    .issueque_rt_data (issueque_rt_data),
    .issueque_imm     (issueque_imm),
    .issueque_rd_tag  (issueque_rd_tag),
    .issueque_opcode  (issueque_opcode),
    .issueblk_done    (issueblk_done),
    .cdb_req          (cdb_req),
    .cdb_grant        (cdb_grant),
    .cdb_out_tag      (cdb_out_tag),
    .cdb_out_data     (cdb_out_data),
    .lsu_busy         (lsu_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  int last_acc;

  logic [31:0] ref_mem [256];
  int          written_q[$];

  function automatic int ref_index(logic [31:0] rs, logic [31:0] imm);
    logic [31:0] ea;
    ea = rs + imm;
    return int'((ea / 4) % 256);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_junk();
    issueque_rs_data = $urandom;
    issueque_rt_data = $urandom;
    issueque_imm     = $urandom;
    issueque_rd_tag  = 6'($urandom);
    issueque_opcode  = 1'($urandom);
  endtask

  // Called just after a negedge with the unit idle; returns at the IDLE
  // cycle following the store's EXEC cycle.
  task automatic do_store(logic [31:0] rs, logic [31:0] imm, logic [31:0] rt);
    int idx;
    issueque_ready   = 1'b1;
    issueque_opcode  = 1'b1;
    issueque_rs_data = rs;
    issueque_imm     = imm;
    issueque_rt_data = rt;
    issueque_rd_tag  = 6'($urandom);
    cdb_grant        = 1'($urandom);
    #1;
    chk("st_accept_done", 32'(issueblk_done), 32'd1);
    chk("st_accept_busy", 32'(lsu_busy), 32'd0);
    last_acc = cyc;
    @(negedge clk);
    drive_junk();
    #1;
    chk("st_exec_done", 32'(issueblk_done), 32'd0);
    chk("st_exec_busy", 32'(lsu_busy), 32'd1);
    chk("st_exec_req", 32'(cdb_req), 32'd0);
    idx = ref_index(rs, imm);
    ref_mem[idx] = rt;
    written_q.push_back(idx);
    @(negedge clk);
    issueque_ready = 1'b0;
    cdb_grant      = 1'b0;
  endtask

  // Load with `stall` cycles of withheld grant; ready held high while busy.
  task automatic do_load(logic [31:0] rs, logic [31:0] imm, logic [5:0] tag, int stall);
    logic [31:0] exp_data;
    exp_data = ref_mem[ref_index(rs, imm)];
    issueque_ready   = 1'b1;
    issueque_opcode  = 1'b0;
    issueque_rs_data = rs;
    issueque_imm     = imm;
    issueque_rt_data = $urandom;
    issueque_rd_tag  = tag;
    cdb_grant        = 1'b0;
    #1;
    chk("ld_accept_done", 32'(issueblk_done), 32'd1);
    last_acc = cyc;
    @(negedge clk);
    drive_junk();
    cdb_grant = 1'($urandom);
    #1;
    chk("ld_exec_done", 32'(issueblk_done), 32'd0);
    chk("ld_exec_busy", 32'(lsu_busy), 32'd1);
    chk("ld_exec_req", 32'(cdb_req), 32'd0);
    @(negedge clk);
    for (int i = 0; i <= stall; i++) begin
      cdb_grant = (i == stall);
      if (i == stall) issueque_ready = 1'b0;
      #1;
      chk("ld_wb_req", 32'(cdb_req), 32'd1);
      chk("ld_wb_tag", 32'(cdb_out_tag), 32'(tag));
      chk("ld_wb_data", cdb_out_data, exp_data);
      chk("ld_wb_done", 32'(issueblk_done), 32'd0);
      @(negedge clk);
    end
    cdb_grant = 1'b0;
    #1;
    chk("ld_post_req", 32'(cdb_req), 32'd0);
    chk("ld_post_busy", 32'(lsu_busy), 32'd0);
    chk("ld_post_tag_hold", 32'(cdb_out_tag), 32'(tag));
    chk("ld_post_data_hold", cdb_out_data, exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, idx;
    logic [31:0] r, ea, rs, exp_d;

    // Reset with ready asserted: nothing may be accepted.
    reset = 1'b1;
    issueque_ready   = 1'b1;
    issueque_opcode  = 1'b1;
    issueque_rs_data = 32'h100;
    issueque_imm     = 32'h0;
    issueque_rt_data = 32'h1;
    issueque_rd_tag  = 6'd3;
    cdb_grant        = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_done", 32'(issueblk_done), 32'd0);
    chk("rst_req", 32'(cdb_req), 32'd0);
    chk("rst_tag", 32'(cdb_out_tag), 32'd0);
    chk("rst_data", cdb_out_data, 32'd0);
    chk("rst_busy", 32'(lsu_busy), 32'd0);
    @(negedge clk);
    reset          = 1'b0;
    issueque_ready = 1'b0;
    cdb_grant      = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_busy", 32'(lsu_busy), 32'd0);
    chk("post_rst_req", 32'(cdb_req), 32'd0);

    // Store then load to the same word, immediate grant.
    do_store(32'h100, 32'h8, 32'hDEADBEEF);
    do_load(32'h104, 32'h4, 6'd12, 0);
    chk("st_ld_data_direct", cdb_out_data, 32'hDEADBEEF);

    // CDB stall: 5 cycles without grant, then grant.
    @(negedge clk);
    do_load(32'h100, 32'h8, 6'd33, 5);

    // Aliasing: upper and byte-offset bits ignored.
    @(negedge clk);
    do_store(32'h0000_0403, 32'h0, 32'h12345678);
    do_load(32'h0, 32'h0, 6'd7, 0);
    chk("alias_data", cdb_out_data, 32'h12345678);

    // Address wrap: 0xFFFFFFFC + 8 -> word 1.
    @(negedge clk);
    do_store(32'hFFFF_FFFC, 32'h8, 32'hCAFE_F00D);
    do_load(32'h4, 32'h0, 6'd9, 0);
    chk("wrap_data", cdb_out_data, 32'hCAFE_F00D);

    // Back-to-back SW/LW/SW with ready held high.
    @(negedge clk);
    do_store(32'h200, 32'h10, 32'h0BAD_CAFE);
    t0 = last_acc;
    do_load(32'h210, 32'h0, 6'd21, 0);
    t1 = last_acc;
    do_store(32'h300, 32'h0, 32'h1357_9BDF);
    t2 = last_acc;
    chk("b2b_second_accept", 32'(t1 - t0), 32'd2);
    chk("b2b_third_accept", 32'(t2 - t0), 32'd5);

    // Reset during EXEC of a store to word 5 leaves the old value.
    @(negedge clk);
    do_store(32'h14, 32'h0, 32'hAAAA_AAAA);
    issueque_ready   = 1'b1;
    issueque_opcode  = 1'b1;
    issueque_rs_data = 32'h14;
    issueque_imm     = 32'h0;
    issueque_rt_data = 32'h5555_5555;
    #1;
    chk("rst_st_accept", 32'(issueblk_done), 32'd1);
    @(negedge clk);
    issueque_ready = 1'b0;
    #1;
    chk("rst_st_exec_busy", 32'(lsu_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_st_busy_drop", 32'(lsu_busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_load(32'h10, 32'h4, 6'd5, 0);
    chk("rst_st_old_value", cdb_out_data, 32'hAAAA_AAAA);

    // Reset during WB drops cdb_req immediately.
    @(negedge clk);
    issueque_ready   = 1'b1;
    issueque_opcode  = 1'b0;
    issueque_rs_data = 32'h108;
    issueque_imm     = 32'h0;
    issueque_rd_tag  = 6'd40;
    cdb_grant        = 1'b0;
    @(negedge clk);
    issueque_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_wb_req_before", 32'(cdb_req), 32'd1);
    chk("rst_wb_data_before", cdb_out_data, 32'hDEADBEEF);
    reset = 1'b1;
    #1;
    chk("rst_wb_req_drop", 32'(cdb_req), 32'd0);
    chk("rst_wb_tag_clr", 32'(cdb_out_tag), 32'd0);
    chk("rst_wb_data_clr", cdb_out_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Randomized mix against the array model.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_store($urandom, $urandom, $urandom);
      end else begin
        idx   = written_q[$urandom_range(0, written_q.size() - 1)];
        r     = $urandom;
        ea    = {r[31:10], 8'(idx), r[1:0]};
        rs    = $urandom;
        exp_d = ref_mem[idx];
        do_load(rs, ea - rs, 6'($urandom), $urandom_range(0, 2));
        chk("rnd_ld_data", cdb_out_data, exp_d);
        @(negedge clk);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_exec_unit.md
Name: lsu_exec_unit

Overview:
- Load/store execution unit directly downstream of the LW/SW issue queue.
- Accepts the oldest ready memory instruction from the queue head and computes effective address = base + immediate.
- Stores write an internal word-addressed data memory; loads read it and broadcast the result on the CDB through a request/grant arbiter.
- Processes one instruction at a time; program order is inherited from the in-order queue.

Parameters:
- MEM_DEPTH, 256, number of 32-bit words in the data memory; power of 2, ≥ 4.
- AW, $clog2(MEM_DEPTH), word-index width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- issueque_ready  in  1  queue head valid with both operands valid.
- issueque_rs_data  in  32  base address (rs1).
- issueque_rt_data  in  32  store data (rs2); ignored for loads.
- issueque_imm  in  32  sign-extended offset from queue head.
- issueque_rd_tag  in  6  destination tag for load result.
- issueque_opcode  in  1  0 = load (LW), 1 = store (SW).
- issueblk_done  out  1  accept strobe; queue pops head on done && ready.
- cdb_req  out  1  load result pending broadcast.
- cdb_grant  in  1  arbiter grant; meaningful only while cdb_req = 1.
- cdb_out_tag  out  6  tag of the load result.
- cdb_out_data  out  32  load result data.
- lsu_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset is asynchronous, active-high; clock is clk. While reset is asserted and after it:
  - state = IDLE;
  - issueblk_done = 0, cdb_req = 0, cdb_out_tag = 0, cdb_out_data = 0, lsu_busy = 0;
  - internal latches cleared.
- Memory array contents are not reset (undefined at power-up, unchanged by reset).
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - issueblk_done = issueque_ready (combinational, only in IDLE).
  - If issueque_ready, on the clock edge latch opcode, rd_tag, rt_data and ea = rs_data + imm (32-bit, wrap modulo 2^32, carry dropped), then go to EXEC.
  - Otherwise stay in IDLE.
- Word index = ea[AW+1:2]:
  - ea[1:0] ignored (no misalignment trap);
  - bits above AW+1 ignored, so addresses alias modulo MEM_DEPTH words.
- EXEC, store: mem[index] <= rt_data on this edge; next state IDLE. No CDB activity.
- EXEC, load: synchronous read; mem[index] is registered into cdb_out_data, rd_tag into cdb_out_tag; next state WB.
- WB:
  - cdb_req = 1; tag/data held stable until granted.
  - On cdb_grant = 1, go to IDLE and drop cdb_req next cycle.
  - If cdb_grant = 0, stay in WB indefinitely.
- issueblk_done is never asserted outside IDLE, so the unit accepts nothing while busy. Back-pressure is fully carried by done.
- Latency:
  - Store: accept at cycle T, memory updated at the end of T+1, next accept possible at T+2.
  - Load: accept at T, cdb_req high at T+2; with immediate grant, back in IDLE at T+3, next accept at T+3.
- Read-after-write: a store committed in EXEC at cycle N is visible to a load whose EXEC is at any cycle > N. Guaranteed by serialization; no forwarding needed.
- cdb_out_tag and cdb_out_data hold their last values after a grant (not cleared). Consumers qualify with cdb_req / CDB valid.
- Reset mid-operation: any in-flight instruction is dropped. A store whose EXEC edge coincides with reset assertion is not written. cdb_req falls immediately (asynchronously).
- cdb_grant while not in WB: ignored.
- issueque_ready toggling while busy: ignored. The queue keeps its head because done = 0.

Test Plan:
- Reset → all outputs 0, lsu_busy = 0; assert issueque_ready in the same cycle as reset → issueblk_done stays 0 and no accept occurs.
- Store then load: SW rs = 0x100, imm = 0x8, rt = 0xDEADBEEF; then LW rs = 0x104, imm = 0x4, tag = 6'd12, grant held high.
  - Required: done pulses once per instruction.
  - Required: cdb_req = 1 with tag 12, data 0xDEADBEEF exactly 2 cycles after the load accept, then low the following cycle.
- CDB stall: load pending in WB with cdb_grant = 0 for 5 cycles, then 1.
  - Required: cdb_req, tag and data stable for all 6 cycles.
  - Required: issueblk_done = 0 throughout despite issueque_ready = 1.
- Address wrap and alias (MEM_DEPTH = 256):
  - SW to ea 0x0000_0403 with data 0x12345678, then LW ea 0x0000_0000 → data 0x12345678 (index 0; low bits and upper bits ignored).
  - rs = 0xFFFF_FFFC, imm = 0x8 → ea 0x4, index 1.
- Back-to-back: issueque_ready held high with 3 alternating SW/LW.
  - Required: done asserted only in IDLE cycles, at accept cycles T, T+2, T+5 (with immediate grant).
- Reset asserted during EXEC of a store to index 5, holding old value 0xAAAA_AAAA → index 5 still reads 0xAAAA_AAAA afterwards; reset asserted during WB → cdb_req drops the same cycle.
